// File: rtl/percept_pkg.sv
// Shared constants, opcodes and FSM state type for the percept link.
// FRAME_BITS includes the parity bit when PERCEPT_TX_PARITY_EN is defined.
package percept_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int OP_W_DEF   = 3;
    localparam int DATA_W_DEF = 62;

`ifdef PERCEPT_TX_PARITY_EN
    localparam int FRAME_BITS = 1 + ADDR_W_DEF + OP_W_DEF + DATA_W_DEF + 1;
`else
    localparam int FRAME_BITS = 1 + ADDR_W_DEF + OP_W_DEF + DATA_W_DEF;
`endif

    localparam logic [2:0] OP_NOP    = 3'h0;
    localparam logic [2:0] OP_READ   = 3'h1;
    localparam logic [2:0] OP_PING   = 3'h2;
    localparam logic [2:0] OP_ACK    = 3'h3;
    localparam logic [2:0] OP_WRITE  = 3'h4;
    localparam logic [2:0] OP_BCAST  = 3'h5;

    typedef enum logic [2:0] {
        IDLE,
        START,
        SHIFT,
        PARITY,
        GAP
    } tx_state_e;

endpackage

// File: rtl/percept_bit_timer.sv
// Bit-period timer: tick marks the final clock of each BIT_CYCLES-long bit while run is high.
// tick_pre flags that the next clock will be a tick, letting the caller register pulses early.
module percept_bit_timer #(
    parameter int BIT_CYCLES = 1
) (
    input  logic clk,
    input  logic Rst,
    input  logic run,
    output logic tick,
    output logic tick_pre
);

    localparam int               CNT_W    = $clog2(BIT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            cnt_q <= '0;
        end else if (!run || cnt_q == CNT_LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign tick = run && (cnt_q == CNT_LAST);

    generate
        if (BIT_CYCLES == 1) begin : g_single
            // Every running clock is a bit boundary, so the next one is too.
            assign tick_pre = run;
        end else begin : g_multi
            assign tick_pre = run && (cnt_q == CNT_W'(BIT_CYCLES - 2));
        end
    endgenerate

endmodule

// File: rtl/percept_frame_tx.sv
// Percept link frame transmitter: start bit, {addr,op,data} MSB-first, then an idle-high gap.
// Defining PERCEPT_TX_PARITY_EN appends an even-parity bit after the payload.
module percept_frame_tx
    import percept_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int OP_W       = OP_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int BIT_CYCLES = 1,
    parameter int GAP_BITS   = 2
) (
    input  logic              clk,
    input  logic              Rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [OP_W-1:0]   in_op,
    input  logic [DATA_W-1:0] in_data,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int PB      = ADDR_W + OP_W + DATA_W;
    localparam int LAST    = PB - 1;
    localparam int CNT_MAX = (PB > GAP_BITS) ? PB : GAP_BITS;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] LAST_C     = CNT_W'(LAST);
    localparam logic [CNT_W-1:0] LAST_M1_C  = CNT_W'(LAST - 1);
    localparam logic [CNT_W-1:0] GAP_LAST_C = CNT_W'(GAP_BITS - 1);
    localparam logic [CNT_W-1:0] GAP_M2_C   = CNT_W'(GAP_BITS - 2);

    tx_state_e        state_q;
    logic [PB-1:0]    shreg_q;
    logic [PB-1:0]    shreg_shift;
    logic [CNT_W-1:0] bit_q;
    logic             tx_q;
    logic             in_ready_q;
    logic             busy_q;
    logic             done_q;
    logic             done_d;
`ifdef PERCEPT_TX_PARITY_EN
    logic             parity_q;
`endif

    logic run;
    logic tick;
    logic tick_pre;
    logic accept;
    logic fin_next;
    logic adv_fin;

    assign run         = (state_q != IDLE);
    assign accept      = in_valid && in_ready_q;
    assign shreg_shift = shreg_q << 1;
    // fin_next: the next clock is the final clock of the current bit.
    // adv_fin: a bit boundary is now and the following bit is a single clock long.
    assign fin_next    = tick_pre && !tick;
    assign adv_fin     = tick && tick_pre;

    percept_bit_timer #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .Rst     (Rst),
        .run     (run),
        .tick    (tick),
        .tick_pre(tick_pre)
    );

    // done is registered, so it is raised one clock ahead of the bit it marks.
    always_comb begin
        done_d = 1'b0;
`ifdef PERCEPT_TX_PARITY_EN
        if (state_q == PARITY && fin_next) begin
            done_d = 1'b1;
        end
        if (state_q == SHIFT && bit_q == LAST_C && adv_fin) begin
            done_d = 1'b1;
        end
`else
        if (state_q == SHIFT && bit_q == LAST_C && fin_next) begin
            done_d = 1'b1;
        end
        if (state_q == SHIFT && bit_q == LAST_M1_C && adv_fin) begin
            done_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            bit_q      <= '0;
            tx_q       <= 1'b1;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef PERCEPT_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            done_q <= done_d;
            if (accept) begin
                state_q    <= START;
                shreg_q    <= {in_addr, in_op, in_data};
                bit_q      <= '0;
                tx_q       <= 1'b0;
                in_ready_q <= 1'b0;
                busy_q     <= 1'b1;
`ifdef PERCEPT_TX_PARITY_EN
                parity_q   <= ^{in_addr, in_op, in_data};
`endif
            end else begin
                case (state_q)
                    IDLE: begin
                    end
                    START: begin
                        if (tick) begin
                            state_q <= SHIFT;
                            tx_q    <= shreg_q[PB-1];
                        end
                    end
                    SHIFT: begin
                        if (tick) begin
                            if (bit_q == LAST_C) begin
                                bit_q <= '0;
`ifdef PERCEPT_TX_PARITY_EN
                                state_q <= PARITY;
                                tx_q    <= parity_q;
`else
                                state_q    <= GAP;
                                tx_q       <= 1'b1;
                                in_ready_q <= adv_fin && (GAP_BITS == 1);
`endif
                            end else begin
                                shreg_q <= shreg_shift;
                                tx_q    <= shreg_shift[PB-1];
                                bit_q   <= bit_q + CNT_W'(1);
                            end
                        end
                    end
`ifdef PERCEPT_TX_PARITY_EN
                    PARITY: begin
                        if (tick) begin
                            state_q    <= GAP;
                            tx_q       <= 1'b1;
                            bit_q      <= '0;
                            in_ready_q <= adv_fin && (GAP_BITS == 1);
                        end
                    end
`endif
                    GAP: begin
                        // Ready opens on the last gap clock so a waiting command starts
                        // exactly GAP_BITS bit times after the frame.
                        if (tick) begin
                            if (bit_q == GAP_LAST_C) begin
                                state_q    <= IDLE;
                                busy_q     <= 1'b0;
                                bit_q      <= '0;
                                in_ready_q <= 1'b1;
                            end else begin
                                bit_q      <= bit_q + CNT_W'(1);
                                in_ready_q <= adv_fin && (bit_q == GAP_M2_C);
                            end
                        end else if (fin_next && bit_q == GAP_LAST_C) begin
                            in_ready_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q    <= IDLE;
                        tx_q       <= 1'b1;
                        busy_q     <= 1'b0;
                        in_ready_q <= 1'b1;
                        bit_q      <= '0;
                    end
                endcase
            end
        end
    end

    assign tx       = tx_q;
    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_percept_frame_tx.sv
// Directed bench for percept_frame_tx: waveform checks plus a frame-decoding scoreboard.
module tb_percept_frame_tx;
    import percept_pkg::*;

    localparam int AW = 8;
    localparam int OW = 3;
    localparam int DW = 62;
    localparam int PB = AW + OW + DW;
`ifdef PERCEPT_TX_PARITY_EN
    localparam int NB = PB + 2;
`else
    localparam int NB = PB + 1;
`endif

    logic          clk = 1'b0;
    logic          Rst;
    logic          in_valid,  in_valid4;
    logic [AW-1:0] in_addr,   in_addr4;
    logic [OW-1:0] in_op,     in_op4;
    logic [DW-1:0] in_data,   in_data4;
    logic          in_ready,  in_ready4;
    logic          tx,        tx4;
    logic          busy,      busy4;
    logic          done,      done4;

    int n_pass  = 0;
    int n_total = 0;
    logic [PB-1:0] sb_q[$];

    always #5 clk = ~clk;

    percept_frame_tx #(.BIT_CYCLES(1), .GAP_BITS(2)) dut (
        .clk(clk), .Rst(Rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_op(in_op), .in_data(in_data),
        .tx(tx), .busy(busy), .done(done)
    );

    percept_frame_tx #(.BIT_CYCLES(4), .GAP_BITS(2)) dut4 (
        .clk(clk), .Rst(Rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .in_addr(in_addr4), .in_op(in_op4), .in_data(in_data4),
        .tx(tx4), .busy(busy4), .done(done4)
    );

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [NB-1:0] frame_of(input logic [PB-1:0] p);
`ifdef PERCEPT_TX_PARITY_EN
        return {1'b0, p, ^p};
`else
        return {1'b0, p};
`endif
    endfunction

    // Called at a negedge; returns at the negedge of the start-bit cycle.
    task automatic send(input logic [AW-1:0] a, input logic [OW-1:0] o, input logic [DW-1:0] d);
        int w;
        logic [63:0] r;
        in_valid = 1'b1; in_addr = a; in_op = o; in_data = d;
        w = 0;
        while (in_ready !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("accept_wait", 80'(w < 200), 80'd1);
        sb_q.push_back({a, o, d});
        @(negedge clk);
        r = {$urandom(), $urandom()};
        in_valid = 1'b0; in_addr = r[AW-1:0]; in_op = r[OW-1:0]; in_data = r[DW-1:0];
    endtask

    task automatic check_frame(input string tag, input logic [PB-1:0] p);
        logic [NB-1:0] f;
        int done_at, done_n;
        f = frame_of(p);
        done_at = -1;
        done_n  = 0;
        for (int i = 0; i < NB; i++) begin
            chk($sformatf("%s_bit%0d", tag, i), 80'(tx), 80'(f[NB-1-i]));
            if (done === 1'b1) begin
                done_n++;
                done_at = i;
            end
            @(negedge clk);
        end
        chk({tag, "_done_pos"}, 80'(done_at), 80'(NB - 1));
        chk({tag, "_done_cnt"}, 80'(done_n), 80'd1);
        chk({tag, "_gap0_tx"}, 80'(tx), 80'd1);
        chk({tag, "_gap0_ready"}, 80'(in_ready), 80'd0);
        chk({tag, "_gap0_done"}, 80'(done), 80'd0);
        @(negedge clk);
        chk({tag, "_gap1_tx"}, 80'(tx), 80'd1);
        chk({tag, "_gap1_ready"}, 80'(in_ready), 80'd1);
        chk({tag, "_gap1_busy"}, 80'(busy), 80'd1);
        @(negedge clk);
        chk({tag, "_idle_busy"}, 80'(busy), 80'd0);
        chk({tag, "_idle_ready"}, 80'(in_ready), 80'd1);
        chk({tag, "_idle_tx"}, 80'(tx), 80'd1);
    endtask

    // Scoreboard: decode each frame seen on tx and compare with the oldest accepted command.
    initial begin : monitor
        logic          prev;
        logic [NB-1:0] cap;
        logic [PB-1:0] exp;
        bit            aborted;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (Rst !== 1'b0) begin
                prev = 1'b1;
            end else if (prev === 1'b1 && tx === 1'b0) begin
                cap = '0;
                aborted = 1'b0;
                for (int i = 1; i < NB; i++) begin
                    @(negedge clk);
                    if (Rst !== 1'b0) begin
                        aborted = 1'b1;
                        break;
                    end
                    cap[NB-1-i] = tx;
                end
                if (!aborted) begin
                    chk("sb_has_entry", 80'(sb_q.size() != 0), 80'd1);
                    if (sb_q.size() != 0) begin
                        exp = sb_q.pop_front();
                        chk("sb_addr", 80'(cap[NB-2 -: AW]), 80'(exp[PB-1 -: AW]));
                        chk("sb_op", 80'(cap[NB-2-AW -: OW]), 80'(exp[PB-1-AW -: OW]));
                        chk("sb_data", 80'(cap[NB-2-AW-OW -: DW]), 80'(exp[DW-1:0]));
`ifdef PERCEPT_TX_PARITY_EN
                        chk("sb_parity", 80'(cap[0]), 80'(^exp));
`endif
                    end
                end
                prev = 1'b1;
            end else begin
                prev = tx;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [63:0]   r;
        logic [DW-1:0] d;
        logic [NB-1:0] f4;
        int ready_first, done_at, done_n, w;

        Rst = 1'b1;
        in_valid = 1'b0;  in_addr = '0;  in_op = '0;  in_data = '0;
        in_valid4 = 1'b0; in_addr4 = '0; in_op4 = '0; in_data4 = '0;
        repeat (3) @(negedge clk);
        chk("rst_tx", 80'(tx), 80'd1);
        chk("rst_ready", 80'(in_ready), 80'd1);
        chk("rst_busy", 80'(busy), 80'd0);
        chk("rst_done", 80'(done), 80'd0);
        chk("rst_tx4", 80'(tx4), 80'd1);
        Rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_tx", 80'(tx), 80'd1);
        chk("idle_busy", 80'(busy), 80'd0);

        // Single frame: AA / WRITE / 100
        send(8'hAA, OP_WRITE, 62'd100);
        check_frame("f1", {8'hAA, OP_WRITE, 62'd100});

        // Pattern with random payload
        r = {$urandom(), $urandom()};
        d = r[DW-1:0];
        send(8'h55, 3'h1, d);
        check_frame("f2", {8'h55, 3'h1, d});
        send(8'hAA, OP_WRITE, 62'd101);
        check_frame("f3", {8'hAA, OP_WRITE, 62'd101});

        // Back-to-back with in_valid held high
        r = {$urandom(), $urandom()};
        in_valid = 1'b1; in_addr = 8'h12; in_op = OP_WRITE; in_data = r[DW-1:0];
        sb_q.push_back({8'h12, OP_WRITE, r[DW-1:0]});
        @(negedge clk);
        chk("b2b_a_start", 80'(tx), 80'd0);
        r = {$urandom(), $urandom()};
        in_addr = 8'h34; in_op = 3'h2; in_data = r[DW-1:0];
        sb_q.push_back({8'h34, 3'h2, r[DW-1:0]});
        ready_first = -1;
        for (int c = 1; c <= NB + 1; c++) begin
            @(negedge clk);
            if (c >= NB) chk($sformatf("b2b_gap_tx%0d", c), 80'(tx), 80'd1);
            if (in_ready === 1'b1 && ready_first < 0) ready_first = c;
        end
        chk("b2b_ready_cycle", 80'(ready_first), 80'(NB + 1));
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b_b_start", 80'(tx), 80'd0);
        chk("b2b_b_ready", 80'(in_ready), 80'd0);
        repeat (NB + 4) @(negedge clk);

        // BIT_CYCLES=4 instance: FF / 0 / 0
        in_valid4 = 1'b1; in_addr4 = 8'hFF; in_op4 = 3'h0; in_data4 = '0;
        w = 0;
        while (in_ready4 !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        in_valid4 = 1'b0;
        f4 = frame_of({8'hFF, 3'h0, 62'd0});
        done_at = -1;
        done_n = 0;
        for (int c = 0; c < 4 * NB; c++) begin
            chk($sformatf("bc4_clk%0d", c), 80'(tx4), 80'(f4[NB-1-(c/4)]));
            if (done4 === 1'b1) begin
                done_n++;
                done_at = c;
            end
            @(negedge clk);
        end
        chk("bc4_end_tx", 80'(tx4), 80'd1);
        chk("bc4_done_pos", 80'(done_at), 80'(4 * NB - 1));
        chk("bc4_done_cnt", 80'(done_n), 80'd1);
        repeat (10) @(negedge clk);
        chk("bc4_idle_ready", 80'(in_ready4), 80'd1);

        // Reset mid-frame at bit 30
        send(8'hC3, OP_READ, 62'h1234_5678);
        done_n = 0;
        for (int c = 0; c < 30; c++) begin
            if (done === 1'b1) done_n++;
            @(negedge clk);
        end
        Rst = 1'b1;
        #1;
        chk("abort_tx", 80'(tx), 80'd1);
        chk("abort_busy", 80'(busy), 80'd0);
        chk("abort_ready", 80'(in_ready), 80'd1);
        chk("abort_done", 80'(done), 80'd0);
        repeat (3) @(negedge clk);
        Rst = 1'b0;
        sb_q.delete();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done === 1'b1) done_n++;
        end
        chk("abort_no_done", 80'(done_n), 80'd0);
        r = {$urandom(), $urandom()};
        d = r[DW-1:0];
        send(8'h5A, OP_WRITE, d);
        check_frame("post_rst", {8'h5A, OP_WRITE, d});

        repeat (5) @(negedge clk);
        chk("sb_drained", 80'(sb_q.size()), 80'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
